// File: rtl/qmult_arbiter.sv
// rtl/qmult_arbiter.sv - round-robin shared pipelined Q-format multiplier with tagged, stallable output
module qmult_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int FP_WIDTH   = 24,
    parameter int N_REQ      = 4,
    parameter int SATURATE   = 0,
    parameter int ID_W       = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_REQ-1:0]            s_valid,
    output logic [N_REQ-1:0]            s_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0] s_a,
    input  logic [N_REQ*DATA_WIDTH-1:0] s_b,
    output logic                        o_res_valid,
    input  logic                        i_res_ready,
    output logic [DATA_WIDTH-1:0]       o_res_data,
    output logic [ID_W-1:0]             o_res_id,
    output logic                        o_res_ovf
);

    localparam int PW = 2 * DATA_WIDTH;

    localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // pipeline advance: the whole pipe moves only when the output slot can be replaced
    logic adv;

    // arbitration state and combinational winner
    logic [ID_W-1:0]       last_grant;
    logic                  win_valid;
    logic [ID_W-1:0]       win_idx;
    logic [ID_W-1:0]       cand_idx;
    int                    cand;
    logic                  transfer;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;

    // stage 1 registers (captured operands)
    logic                  v1;
    logic [DATA_WIDTH-1:0] a1;
    logic [DATA_WIDTH-1:0] b1;
    logic [ID_W-1:0]       id1;

    // stage 2 registers (full-width product)
    logic                  v2;
    logic signed [PW-1:0]  p2;
    logic [ID_W-1:0]       id2;

    // multiply and scale helpers
    logic signed [PW-1:0]  a_ext;
    logic signed [PW-1:0]  b_ext;
    logic signed [PW-1:0]  prod;
    logic signed [PW-1:0]  q;
    logic [PW-DATA_WIDTH:0] q_hi;
    logic                  q_fits;
    logic                  ovf;
    logic [DATA_WIDTH-1:0] res;

    assign adv = ~o_res_valid | i_res_ready;

    // round-robin search starting just after the last granted requester
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand     = (int'(last_grant) + k) % N_REQ;
            cand_idx = cand[ID_W-1:0];
            if (!win_valid && s_valid[cand_idx]) begin
                win_valid = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // grant is one-hot, suppressed during stall and while reset is asserted
    assign s_ready  = (win_valid && adv && !i_rst) ? (N_REQ'(1) << win_idx) : '0;
    assign transfer = |(s_valid & s_ready);
    assign sel_a    = s_a[win_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_b    = s_b[win_idx*DATA_WIDTH +: DATA_WIDTH];

    // sign-extend operands so the product is exact at double width
    assign a_ext = {{DATA_WIDTH{a1[DATA_WIDTH-1]}}, a1};
    assign b_ext = {{DATA_WIDTH{b1[DATA_WIDTH-1]}}, b1};
    assign prod  = a_ext * b_ext;

    // scale by arithmetic shift (floor); detect results outside the signed output range
    always_comb begin
        q      = p2 >>> FP_WIDTH;
        q_hi   = q[PW-1:DATA_WIDTH-1];
        q_fits = (&q_hi) | ~(|q_hi);
        ovf    = ~q_fits;
        res    = q[DATA_WIDTH-1:0];
        if (SATURATE != 0 && ovf) begin
            res = q[PW-1] ? MIN_VAL : MAX_VAL;
        end
    end

    // last_grant moves only on an actual operand transfer
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_grant <= ID_W'(N_REQ - 1);
        end else if (transfer) begin
            last_grant <= win_idx;
        end
    end

    // stage 1: capture the winning requester's operands and tag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v1  <= 1'b0;
            a1  <= '0;
            b1  <= '0;
            id1 <= '0;
        end else if (adv) begin
            v1  <= transfer;
            a1  <= sel_a;
            b1  <= sel_b;
            id1 <= win_idx;
        end
    end

    // stage 2: register the full-width signed product
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v2  <= 1'b0;
            p2  <= '0;
            id2 <= '0;
        end else if (adv) begin
            v2  <= v1;
            p2  <= prod;
            id2 <= id1;
        end
    end

    // stage 3: output register, held stable while the consumer stalls
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_res_valid <= 1'b0;
            o_res_data  <= '0;
            o_res_id    <= '0;
            o_res_ovf   <= 1'b0;
        end else if (adv) begin
            o_res_valid <= v2;
            o_res_data  <= res;
            o_res_id    <= id2;
            o_res_ovf   <= ovf;
        end
    end

endmodule
